// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limit and result type for the registered ripple-carry adder
package full_adder_pkg;
  localparam int FA_MAX_WIDTH = 64;
  typedef struct packed {
    logic [FA_MAX_WIDTH-1:0] sum;
    logic                    carry;
  } fa_result_t;
endpackage

// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle; FULL_ADDER_OVF_EN adds the ovf result signal
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] af;
  logic [WIDTH-1:0] bf;
  logic             cf;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
  modport master(output in_valid, af, bf, cf, input out_valid, sum, carry, ovf);
  modport slave(input in_valid, af, bf, cf, output out_valid, sum, carry, ovf);
`else
  modport master(output in_valid, af, bf, cf, input out_valid, sum, carry);
  modport slave(input in_valid, af, bf, cf, output out_valid, sum, carry);
`endif
endinterface

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder, the leaf of the carry chain
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder; FULL_ADDER_OVF_EN adds a registered signed-overflow flag
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  full_adder_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             valid_q;
  assign c[0] = bus.cf;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a_i(bus.af[i]),
      .b_i(bus.bf[i]),
      .c_i(c[i]),
      .s_o(s[i]),
      .c_o(c[i+1])
    );
  end
  // Capture only on valid so idle (possibly X) operands never reach the outputs
  always_comb begin
    sum_d   = bus.in_valid ? s : sum_q;
    carry_d = bus.in_valid ? c[WIDTH] : carry_q;
  end
  // Result and valid registers; reset asserts asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= bus.in_valid;
    end
  end
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;
`ifdef FULL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  // Two's-complement overflow: carries into and out of the sign bit differ
  always_comb ovf_d = bus.in_valid ? (c[WIDTH] ^ c[WIDTH-1]) : ovf_q;
  // Overflow register tracks the sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for WIDTH=1 and WIDTH=8 adders; checks ovf when FULL_ADDER_OVF_EN is defined
module tb_full_adder;
  import full_adder_pkg::*;
  typedef struct {
    fa_result_t r;
    logic       ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t q1[$];
  exp_t q8[$];
  always #5 clk = ~clk;
  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();
  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
    exp_t e;
    e.r.sum   = s;
    e.r.carry = c;
    e.ovf     = o;
    return e;
  endfunction

  task automatic send1(input logic a, input logic b, input logic c, input logic es, input logic ec);
    if1.in_valid = 1'b1;
    if1.af = a;
    if1.bf = b;
    if1.cf = c;
    q1.push_back(mk(64'(es), ec, ec ^ c));
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
    if8.in_valid = 1'b1;
    if8.af = a;
    if8.bf = b;
    if8.cf = c;
    q8.push_back(mk(64'(es), ec, eo));
  endtask

  task automatic send8_rand();
    logic [7:0] a = 8'($urandom());
    logic [7:0] b = 8'($urandom());
    logic       c = 1'($urandom());
    logic [8:0] t = 9'(a) + 9'(b) + 9'(c);
    send8(a, b, c, t[7:0], t[8], (a[7] == b[7]) && (t[7] != a[7]));
  endtask

  // WIDTH=1 monitor: pop and compare whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (if1.out_valid) begin
      if (q1.size() == 0) check("w1 unexpected out_valid", 64'(1), 64'(0));
      else begin
        e = q1.pop_front();
        check("w1 sum", 64'(if1.sum), 64'(e.r.sum[0]));
        check("w1 carry", 64'(if1.carry), 64'(e.r.carry));
`ifdef FULL_ADDER_OVF_EN
        check("w1 ovf", 64'(if1.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  // WIDTH=8 monitor
  always @(negedge clk) begin
    exp_t e;
    if (if8.out_valid) begin
      if (q8.size() == 0) check("w8 unexpected out_valid", 64'(1), 64'(0));
      else begin
        e = q8.pop_front();
        check("w8 sum", 64'(if8.sum), 64'(e.r.sum[7:0]));
        check("w8 carry", 64'(if8.carry), 64'(e.r.carry));
`ifdef FULL_ADDER_OVF_EN
        check("w8 ovf", 64'(if8.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    logic [7:0] es1;
    logic [7:0] ec1;
    es1 = 8'b1001_0110;
    ec1 = 8'b1110_1000;
    if1.in_valid = 1'b0; if1.af = '0; if1.bf = '0; if1.cf = 1'b0;
    if8.in_valid = 1'b0; if8.af = '0; if8.bf = '0; if8.cf = 1'b0;
    repeat (2) @(negedge clk);
    check("reset w8 sum", 64'(if8.sum), 64'(0));
    check("reset w8 carry", 64'(if8.carry), 64'(0));
    check("reset w8 out_valid", 64'(if8.out_valid), 64'(0));
    check("reset w1 out_valid", 64'(if1.out_valid), 64'(0));
`ifdef FULL_ADDER_OVF_EN
    check("reset w8 ovf", 64'(if8.ovf), 64'(0));
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send1(1'(i >> 2), 1'(i >> 1), 1'(i), es1[i], ec1[i]);
      @(negedge clk);
    end
    if1.in_valid = 1'b0;
    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    send8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    send8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    send8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if8.in_valid = 1'b0;
      if8.af = (i == 5) ? 'x : 8'($urandom());
      if8.bf = (i == 5) ? 'x : 8'($urandom());
      if8.cf = (i == 5) ? 1'bx : 1'($urandom());
      @(negedge clk);
      check("hold out_valid", 64'(if8.out_valid), 64'(0));
      check("hold sum", 64'(if8.sum), 64'(8'h46));
      check("hold carry", 64'(if8.carry), 64'(0));
    end
    if8.af = '0; if8.bf = '0; if8.cf = 1'b0;
    @(posedge clk);
    #2;
    check("pre-reset sum", 64'(if8.sum), 64'(8'h46));
    rst_n = 1'b0;
    #1;
    check("async reset sum", 64'(if8.sum), 64'(0));
    check("async reset carry", 64'(if8.carry), 64'(0));
    check("async reset out_valid", 64'(if8.out_valid), 64'(0));
    q1.delete();
    q8.delete();
    @(negedge clk);
    check("in reset sum", 64'(if8.sum), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post-release idle out_valid", 64'(if8.out_valid), 64'(0));
    send8(8'h0A, 8'h05, 1'b1, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    check("first valid after release out_valid", 64'(if8.out_valid), 64'(1));
    for (int n = 0; n < 100; n++) begin
      send8_rand();
      @(negedge clk);
      check("b2b out_valid", 64'(if8.out_valid), 64'(1));
    end
    if8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("w1 scoreboard drained", 64'(q1.size()), 64'(0));
    check("w8 scoreboard drained", 64'(q8.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry adder that adds two WIDTH-bit operands and a carry-in.
- Produces a WIDTH-bit sum and a carry-out one clock after a valid input.
- At the default WIDTH=1 it is the single-bit full adder (af, bf, cf -> sum, carry) used as the arithmetic leaf in datapath exercises. Wider instances chain the same bit cell.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  af/bf/cf qualify this cycle.
- af  in  WIDTH  operand A (unsigned).
- bf  in  WIDTH  operand B (unsigned).
- cf  in  1  carry-in.
- out_valid  out  1  sum/carry hold a fresh result.
- sum  out  WIDTH  registered (af + bf + cf) mod 2^WIDTH.
- carry  out  1  registered carry-out, bit WIDTH of af + bf + cf.
- ovf  out  1  signed overflow; present only with FULL_ADDER_OVF_EN.

Behaviour:
- Reset (rst_n low, asynchronous assert; release synchronous to clk):
  - sum = 0, carry = 0, out_valid = 0, ovf = 0.
  - All outputs stay at these values while rst_n is low.
- Datapath:
  - Per bit i: s_i = a_i ^ b_i ^ c_i and c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i), with c_0 = cf.
  - Ripple order is LSB to MSB. There is no internal pipelining.
- Latency:
  - When in_valid = 1 at rising edge N, sum and carry reflect that edge's af/bf/cf after edge N.
  - out_valid = 1 after edge N.
- Hold:
  - in_valid = 0 at an edge: out_valid goes to 0, and sum/carry keep their previous values (no clock-enable glitching).
  - Back-to-back valids give one result per cycle. There is no backpressure and no ready signal.
- Boundary cases:
  - All-ones + all-ones + 1 gives sum = all-ones and carry = 1.
  - 0 + 0 + 0 gives sum = 0 and carry = 0.
  - Wrap-around discards bits above WIDTH except the carry output.
- Reset mid-stream: an in-flight result is discarded, and out_valid is 0 on the first edge after release unless in_valid = 1 at that edge.
- X on af/bf/cf while in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined: port ovf exists, registered with sum. ovf = c_WIDTH ^ c_{WIDTH-1}, the two's-complement overflow. At WIDTH=1 this is carry ^ cf. It resets to 0 and holds when in_valid = 0.
- Undefined: port ovf and its register are absent. All other behaviour is identical.

Decomposition:
- Package full_adder_pkg:
  - constant FA_MAX_WIDTH = 64.
  - typedef fa_result_t, a struct holding a WIDTH-agnostic sum vector (FA_MAX_WIDTH) and a carry bit, used by bench reference models.
- Sub-module full_adder_cell: a purely combinational 1-bit cell (a, b, cin -> s, cout), instantiated WIDTH times in a generate loop.
- Top level holds only the carry chain, the output registers and the valid register.

Test Plan:
- WIDTH=1, exhaustive sweep of af/bf/cf 000..111, one per cycle with in_valid = 1. One cycle later the sum/carry sequence is 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- WIDTH=8:
  - 8'hFF + 8'h01 + 0 -> sum = 8'h00, carry = 1.
  - 8'hFF + 8'hFF + 1 -> sum = 8'hFF, carry = 1.
  - 8'h7F + 8'h01 + 0 with OVF_EN -> ovf = 1, carry = 0.
- Hold: after the result 8'h12 + 8'h34 + 0 = 8'h46, drive in_valid = 0 with random operands for 5 cycles -> sum stays 8'h46 and out_valid = 0.
- Async reset: assert rst_n = 0 mid-cycle while sum = 8'h46 -> sum = 0, carry = 0 and out_valid = 0 immediately, without waiting for a clk edge.
- Reset release: first valid after release, 8'h0A + 8'h05 + 1 -> sum = 8'h10, carry = 0, out_valid = 1 exactly one edge later.
- Back-to-back throughput: 100 random WIDTH=8 vectors on consecutive cycles -> each output matches the reference (a + b + c) one cycle later, with no bubbles.
